// File: rtl/io_port_responder.sv
// io_port_responder: CPU I/O port block with OUT regs, synced IN ports, RX FIFO.
// Optional rising-edge capture and irq on the IN ports when IO_EDGE_IRQ_EN is defined.
module io_port_responder #(
    parameter int NUM_IN_PORTS = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [7:0]                IO_port_ID,
    input  logic [7:0]                IO_write_data,
    input  logic                      IO_write_strobe,
    input  logic                      IO_read_strobe,
    output logic [7:0]                IO_read_data,
    output logic [31:0]               out_port,
    input  logic [NUM_IN_PORTS*8-1:0] in_pins,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic                      irq
);

    localparam int             IW      = NUM_IN_PORTS * 8;
    localparam int             PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0]     DEPTH_C = 5'(FIFO_DEPTH);
    localparam logic [PW-1:0]  PTR_ONE = PW'(1);

    logic [7:0]    r_out [4];
    logic [IW-1:0] r_sync1;
    logic [IW-1:0] r_sync2;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [4:0]    r_count;
    logic          r_overflow;

    logic          w_wr_out;
    logic          w_wr_ctrl;
    logic          w_rd_rx;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_flush;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic [7:0]    w_status;
    logic [7:0]    w_edge_rd;
    logic [7:0]    w_read_data;

    assign w_wr_out  = IO_write_strobe && (IO_port_ID[7:2] == 6'b000000);
    assign w_wr_ctrl = IO_write_strobe && (IO_port_ID == 8'h22);
    assign w_rd_rx   = IO_read_strobe && (IO_port_ID == 8'h20);

    assign w_empty   = (r_count == 5'd0);
    assign w_full    = (r_count == DEPTH_C);
    assign w_flush   = w_wr_ctrl && IO_write_data[1];
    assign w_ovf_clr = w_wr_ctrl && IO_write_data[0];
    assign w_pop     = w_rd_rx && !w_empty;
    // A full FIFO still takes a push when a pop frees the head slot this cycle.
    assign w_push    = rx_valid && (!w_full || w_pop) && !w_flush;
    assign w_ovf_set = rx_valid && w_full && !w_pop && !w_flush;
    assign w_status  = {r_overflow, w_full, w_empty, r_count};

    // OUT0..OUT3 output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) r_out[i] <= 8'h00;
        end else if (w_wr_out) begin
            r_out[IO_port_ID[1:0]] <= IO_write_data;
        end
    end

    assign out_port = {r_out[3], r_out[2], r_out[1], r_out[0]};

    // Two-flop synchronizer for the asynchronous input pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_pins;
            r_sync2 <= r_sync1;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= 5'd0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= (r_overflow && !w_ovf_clr) || w_ovf_set;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= 5'd0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
                if (w_push && !w_pop)      r_count <= r_count + 5'd1;
                else if (w_pop && !w_push) r_count <= r_count - 5'd1;
            end
        end
    end

    // FIFO storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= rx_data;
    end

`ifdef IO_EDGE_IRQ_EN
    logic [IW-1:0] r_sync3;
    logic [7:0]    r_flags;
    logic          r_irq;
    logic [7:0]    w_rise8;
    logic [7:0]    w_flags_nxt;
    logic          w_rd_edge;

    assign w_rd_edge = IO_read_strobe && (IO_port_ID == 8'h23);

    // Fold per-port rising edges onto one byte; a fresh edge survives a clear
    always_comb begin
        w_rise8 = 8'h00;
        for (int p = 0; p < NUM_IN_PORTS; p++) begin
            w_rise8 = w_rise8 | (r_sync2[p*8 +: 8] & ~r_sync3[p*8 +: 8]);
        end
        w_flags_nxt = (w_rd_edge ? 8'h00 : r_flags) | w_rise8;
    end

    // Third sync stage, edge flags and registered irq
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync3 <= '0;
            r_flags <= 8'h00;
            r_irq   <= 1'b0;
        end else begin
            r_sync3 <= r_sync2;
            r_flags <= w_flags_nxt;
            r_irq   <= |w_flags_nxt;
        end
    end

    assign irq       = r_irq;
    assign w_edge_rd = r_flags;
`else
    assign irq       = 1'b0;
    assign w_edge_rd = 8'h00;
`endif

    // Combinational read mux, independent of the read strobe
    always_comb begin
        w_read_data = 8'h00;
        case (IO_port_ID)
            8'h00, 8'h01, 8'h02, 8'h03: w_read_data = r_out[IO_port_ID[1:0]];
            8'h10, 8'h11, 8'h12, 8'h13: begin
                for (int p = 0; p < NUM_IN_PORTS; p++) begin
                    if (IO_port_ID[1:0] == 2'(p)) w_read_data = r_sync2[p*8 +: 8];
                end
            end
            8'h20:   w_read_data = w_empty ? 8'h00 : r_mem[r_rd_ptr];
            8'h21:   w_read_data = w_status;
            8'h23:   w_read_data = w_edge_rd;
            default: w_read_data = 8'h00;
        endcase
    end

    assign IO_read_data = w_read_data;

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: register table plus FIFO/sync/reset sequences.
// Edge/irq checks follow the IO_EDGE_IRQ_EN setting of the build.
module tb_io_port_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  IO_port_ID;
    logic [7:0]  IO_write_data;
    logic        IO_write_strobe;
    logic        IO_read_strobe;
    logic [7:0]  IO_read_data;
    logic [31:0] out_port;
    logic [31:0] in_pins;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       wr;
        logic       rd;
        logic [7:0] exp;
    } vec_t;

    vec_t tv [18];

    always #5 clk = ~clk;

    io_port_responder #(.NUM_IN_PORTS(4), .FIFO_DEPTH(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .IO_port_ID      (IO_port_ID),
        .IO_write_data   (IO_write_data),
        .IO_write_strobe (IO_write_strobe),
        .IO_read_strobe  (IO_read_strobe),
        .IO_read_data    (IO_read_data),
        .out_port        (out_port),
        .in_pins         (in_pins),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .irq             (irq)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e, input string nm);
        IO_port_ID     = a;
        IO_read_strobe = 1'b1;
        @(negedge clk);
        chk(nm, {24'h0, IO_read_data}, {24'h0, e});
        tick();
        IO_read_strobe = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        IO_port_ID      = a;
        IO_write_data   = d;
        IO_write_strobe = 1'b1;
        tick();
        IO_write_strobe = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic [7:0] a, input logic [7:0] d,
                                input logic w, input logic r, input logic [7:0] e);
        vec_t v;
        v.addr = a; v.wdata = d; v.wr = w; v.rd = r; v.exp = e;
        return v;
    endfunction

    initial begin
        tv[0]  = mk(8'h21, 8'h00, 1'b0, 1'b1, 8'h20);
        tv[1]  = mk(8'h00, 8'h00, 1'b0, 1'b1, 8'h00);
        tv[2]  = mk(8'h02, 8'h00, 1'b0, 1'b1, 8'hA5);
        tv[3]  = mk(8'h00, 8'h11, 1'b1, 1'b0, 8'h00);
        tv[4]  = mk(8'h01, 8'h22, 1'b1, 1'b0, 8'h00);
        tv[5]  = mk(8'h03, 8'h44, 1'b1, 1'b0, 8'h00);
        tv[6]  = mk(8'h00, 8'h00, 1'b0, 1'b1, 8'h11);
        tv[7]  = mk(8'h01, 8'h00, 1'b0, 1'b1, 8'h22);
        tv[8]  = mk(8'h03, 8'h00, 1'b0, 1'b1, 8'h44);
        tv[9]  = mk(8'h02, 8'h00, 1'b0, 1'b1, 8'hA5);
        tv[10] = mk(8'h04, 8'hFF, 1'b1, 1'b0, 8'h00);
        tv[11] = mk(8'h04, 8'h00, 1'b0, 1'b1, 8'h00);
        tv[12] = mk(8'hFF, 8'h00, 1'b0, 1'b1, 8'h00);
        tv[13] = mk(8'h21, 8'hFF, 1'b1, 1'b0, 8'h00);
        tv[14] = mk(8'h21, 8'h00, 1'b0, 1'b1, 8'h20);
        tv[15] = mk(8'h00, 8'h77, 1'b1, 1'b1, 8'h11);
        tv[16] = mk(8'h00, 8'h00, 1'b0, 1'b1, 8'h77);
        tv[17] = mk(8'h23, 8'h00, 1'b0, 1'b1, 8'h00);

        reset_n         = 1'b0;
        IO_port_ID      = 8'h21;
        IO_write_data   = 8'h00;
        IO_write_strobe = 1'b0;
        IO_read_strobe  = 1'b0;
        in_pins         = 32'h0;
        rx_valid        = 1'b0;
        rx_data         = 8'h00;
        repeat (3) tick();
        chk("rst_status", {24'h0, IO_read_data}, 32'h20);
        chk("rst_out", out_port, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        tick();

        wr(8'h02, 8'hA5);
        chk("out2_next", out_port, 32'h00A50000);

        for (int i = 0; i < 18; i++) begin
            IO_port_ID      = tv[i].addr;
            IO_write_data   = tv[i].wdata;
            IO_write_strobe = tv[i].wr;
            IO_read_strobe  = tv[i].rd;
            @(negedge clk);
            if (tv[i].rd) chk($sformatf("vec%0d", i), {24'h0, IO_read_data}, {24'h0, tv[i].exp});
            tick();
            IO_write_strobe = 1'b0;
            IO_read_strobe  = 1'b0;
        end
        chk("out_all", out_port, 32'h44A52277);

        in_pins = 32'hDDCCBB3C;
        tick();
        rd(8'h10, 8'h00, "in0_t1");
        rd(8'h10, 8'h3C, "in0_t2");
        rd(8'h11, 8'hBB, "in1");
        rd(8'h13, 8'hDD, "in3");
        rd(8'h14, 8'h00, "in_unmapped");

        for (int i = 1; i <= 9; i++) push(8'(i));
        rd(8'h21, 8'hC8, "stat_ovf_full");
        for (int i = 1; i <= 8; i++) rd(8'h20, 8'(i), $sformatf("pop%0d", i));
        rd(8'h20, 8'h00, "pop_empty");
        rd(8'h21, 8'hA0, "stat_empty_ovf");
        wr(8'h22, 8'h01);
        rd(8'h21, 8'h20, "stat_ovf_clr");

        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        rd(8'h20, 8'h10, "full_pushpop");
        rx_valid = 1'b0;
        rd(8'h21, 8'h48, "stat_full_pp");
        for (int i = 1; i < 8; i++) rd(8'h20, 8'h10 + 8'(i), $sformatf("fpop%0d", i));
        rd(8'h20, 8'h55, "fpop_last");
        rd(8'h21, 8'h20, "stat_after_fpop");

        rx_valid = 1'b1;
        rx_data  = 8'h66;
        rd(8'h20, 8'h00, "empty_pushpop");
        rx_valid = 1'b0;
        rd(8'h21, 8'h01, "stat_cnt1");
        rd(8'h20, 8'h66, "pop_66");

        for (int i = 0; i < 9; i++) push(8'hE0 + 8'(i));
        for (int i = 0; i < 3; i++) rd(8'h20, 8'hE0 + 8'(i), $sformatf("epop%0d", i));
        rd(8'h21, 8'h85, "stat_cnt5_ovf");
        wr(8'h22, 8'h03);
        rd(8'h21, 8'h20, "stat_flush_clr");

        push(8'h31);
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        wr(8'h22, 8'h02);
        rx_valid = 1'b0;
        rd(8'h21, 8'h20, "stat_flush_push");
        rd(8'h20, 8'h00, "flush_empty_rd");

        push(8'h01);
        push(8'h02);
        rx_valid       = 1'b1;
        rx_data        = 8'h03;
        IO_port_ID     = 8'h20;
        IO_read_strobe = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        IO_port_ID = 8'h21;
        #1;
        chk("midrst_status", {24'h0, IO_read_data}, 32'h20);
        chk("midrst_out", out_port, 32'h0);
        rx_valid       = 1'b0;
        IO_read_strobe = 1'b0;
        tick();
        #2;
        reset_n = 1'b1;
        tick();
        rd(8'h21, 8'h20, "postrst_status");
        rd(8'h20, 8'h00, "postrst_rx");

`ifdef IO_EDGE_IRQ_EN
        in_pins = 32'h0;
        repeat (4) tick();
        IO_port_ID     = 8'h23;
        IO_read_strobe = 1'b1;
        tick();
        IO_read_strobe = 1'b0;
        tick();
        in_pins = 32'h00000008;
        begin
            int k;
            k = 0;
            while (!irq && k < 4) begin
                tick();
                k++;
            end
        end
        chk("irq_rise", {31'h0, irq}, 32'h1);
        rd(8'h23, 8'h08, "edge_flags");
        chk("irq_clear", {31'h0, irq}, 32'h0);
`else
        in_pins = 32'h0;
        repeat (3) tick();
        in_pins = 32'h00000008;
        repeat (5) tick();
        chk("irq_off", {31'h0, irq}, 32'h0);
        rd(8'h23, 8'h00, "edge_off");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_port_responder.md
IO_PORT_RESPONDER -- requirements
Module: io_port_responder

Interface
REQ-001 SHALL have parameter NUM_IN_PORTS, default 4, number of synchronized 8-bit input ports (1..4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, RX FIFO entries (power of two, 2..16).
REQ-003 SHALL have clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have IO_port_ID, input, 8, port address from the EX/MEMWB pipeline.
REQ-006 SHALL have IO_write_data, input, 8, CPU output data.
REQ-007 SHALL have IO_write_strobe, input, 1, one-cycle write qualifier.
REQ-008 SHALL have IO_read_strobe, input, 1, one-cycle read qualifier.
REQ-009 SHALL have IO_read_data, output, 8, read data for IO_port_ID.
REQ-010 SHALL have out_port, output, 32, registers OUT0..OUT3, OUT0 in [7:0].
REQ-011 SHALL have in_pins, input, NUM_IN_PORTS*8, asynchronous input pins, IN0 in [7:0].
REQ-012 SHALL have rx_valid / rx_data, input, 1 / 8, one-cycle push of a byte into the RX FIFO.
REQ-013 SHALL have irq, output, 1, edge-capture interrupt (see Configuration).

Function
REQ-014 Port map: 0x00-0x03 OUTn (R/W); 0x10-0x13 INn (R); 0x20 RX data (R, pops); 0x21 status (R); 0x22 control (W); 0x23 edge flags (R, clears).
REQ-015 IO_read_data SHALL be combinational from IO_port_ID and current state, independent of IO_read_strobe; it is sampled in the strobe cycle.
REQ-016 Unmapped addresses and INn with n >= NUM_IN_PORTS SHALL read 0x00; writes to read-only or unmapped addresses SHALL be ignored.
REQ-017 Write with IO_write_strobe=1 to 0x00-0x03 SHALL update OUTn at that edge; out_port reflects it the next cycle.
REQ-018 in_pins SHALL pass through a 2-flop synchronizer; INn reads the second stage, a 2-cycle latency from pin to readable value.
REQ-019 RX FIFO: push when rx_valid=1 and not full; pop when IO_read_strobe=1, IO_port_ID=0x20 and not empty; pointers wrap modulo FIFO_DEPTH.
REQ-020 Reading 0x20 SHALL return the head entry; when the FIFO is empty it returns 0x00 and no pop occurs.
REQ-021 Push while full SHALL drop the byte and set sticky overflow; push and pop in the same cycle while full SHALL accept the push, with count unchanged.
REQ-022 Push and pop in the same cycle while empty SHALL accept the push only; count becomes 1.
REQ-023 Status 0x21 = {overflow, full, empty, count[4:0]}.
REQ-024 Write to 0x22 with bit0=1 SHALL clear overflow; bit1=1 SHALL flush the FIFO (pointers and count to 0); a concurrent push in the flush cycle SHALL be discarded.
REQ-025 Simultaneous read and write strobes SHALL both be honoured, each using the same IO_port_ID.

Reset
REQ-026 reset_n=0 SHALL asynchronously clear OUT0..OUT3, synchronizer flops, FIFO pointers, count, overflow, edge flags and irq to 0.
REQ-027 FIFO storage SHALL NOT be reset; after reset the status register reads 0x20.
REQ-028 Reset asserted mid-operation SHALL discard in-flight push and pop, with no partial update after release.

Configuration
REQ-029 Macro IO_EDGE_IRQ_EN defined: each bit of synchronized IN0..IN(NUM_IN_PORTS-1) SHALL detect rising edges by comparing against a third stage.
REQ-030 With IO_EDGE_IRQ_EN defined, detected rising edges SHALL OR into an 8-bit flag register at 0x23 (flag bit i = OR over ports of bit i).
REQ-031 With IO_EDGE_IRQ_EN defined, a read strobe at 0x23 SHALL clear the flags; an edge arriving in the same cycle SHALL remain set.
REQ-032 With IO_EDGE_IRQ_EN defined, irq SHALL be the registered OR of the flags.
REQ-033 Without IO_EDGE_IRQ_EN, 0x23 SHALL read 0x00 and irq SHALL be tied to 0; no edge logic is synthesized.

Verification
REQ-034 Write 0xA5 to 0x02 -> out_port[23:16]=0xA5 next cycle; reading 0x02 returns 0xA5; other OUTn unchanged.
REQ-035 in_pins[7:0] changes 0x00->0x3C at edge T -> reading 0x10 returns 0x00 at T+1 and 0x3C from T+2.
REQ-036 Push 9 bytes 0x01..0x09 with FIFO_DEPTH=8 -> status reads 0xC8; eight pops return 0x01..0x08; a ninth read returns 0x00; status then reads 0xA0.
REQ-037 Full FIFO with simultaneous push 0x55 and pop -> pop returns the oldest byte, count stays 8, 0x55 is last out, overflow is not newly set.
REQ-038 Write 0x22 with value 0x03 while count=5 and overflow=1 -> status reads 0x20 next cycle.
REQ-039 With IO_EDGE_IRQ_EN, IN0 bit3 rises -> irq=1 within 4 cycles and 0x23 reads 0x08; after that read irq=0 the next cycle; without the macro irq stays 0.
